fetch_decode_queue: RTL and testbench
=====================================

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; SHALL be a power of two, >= 2.
REQ-002 Parameter XLEN, default 64, fetch data width.
REQ-003 Parameter ADDR_W, default 64, instruction address width.
REQ-004 Parameter PC_RESET, default 64'h8000_0000, address shown when empty.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rstn  in  1  reset; synchronous, active-low.
REQ-007 in_valid  in  1  fetch presents an entry.
REQ-008 in_ready  out  1  queue accepts an entry this cycle.
REQ-009 in_addr  in  ADDR_W  fetch address.
REQ-010 in_data  in  XLEN  fetched instruction word.
REQ-011 in_cinstr  in  2  [0] primary slot compressed, [1] aux slot compressed.
REQ-012 in_cancel  in  2  [0] primary cancelled, [1] aux cancelled (1 = cancelled).
REQ-013 bpu_taken  in  1  predictor redirected after the primary slot of the incoming entry.
REQ-014 flush  in  1  pipeline flush; discard all queued and incoming entries.
REQ-015 out_valid  out  1  head entry available to decode.
REQ-016 out_ready  in  1  decode consumes the head entry; low = hold.
REQ-017 out_addr, out_data, out_cinstr, out_cancel  out  ADDR_W/XLEN/2/2  head entry fields.
REQ-018 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the write pointer.
REQ-020 Pop SHALL occur when out_valid && out_ready && !flush; the read pointer advances.
REQ-021 in_ready SHALL be (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-022 out_valid SHALL be (count != 0); head fields SHALL be driven from storage at the read pointer.
REQ-023 When count == 0, outputs SHALL be out_addr = PC_RESET, out_data = 0, out_cinstr = 2'b00, out_cancel = 2'b11.
REQ-024 Stored cancel on push: if bpu_taken, then {1, in_cancel[0]}; otherwise in_cancel unchanged.
REQ-025 An entry pushed in cycle N SHALL appear at the head no earlier than cycle N+1; minimum pass-through latency is 1 cycle.
REQ-026 Push only: count +1. Pop only: count -1. Push and pop together: count unchanged, both pointers advance.
REQ-027 When full, in_ready = 0; a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-028 When empty, no pop occurs regardless of out_ready.
REQ-029 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-030 Flush SHALL, on the next edge, clear count and both pointers to 0; a simultaneous push and pop are discarded.
REQ-031 Storage contents need not be cleared by flush or reset; only pointers and count are cleared.
REQ-032 Flush has priority over push and pop; reset has priority over flush.

Reset
REQ-033 While rstn = 0 at a clock edge, the following SHALL be set: count = 0, pointers = 0, in_ready = 1, out_valid = 0, and outputs per REQ-023.
REQ-034 Reset asserted mid-operation SHALL discard all entries, with no partial push or pop.

Verification
REQ-035 Push A (addr 0x1000, data 0x13, cancel 00) into an empty queue with out_ready = 0 -> next cycle out_valid = 1, out_addr = 0x1000, count = 1.
REQ-036 Push 4 entries with out_ready = 0 (DEPTH = 4) -> count = 4, in_ready = 0; a fifth in_valid is not accepted; pop -> next cycle in_ready = 1.
REQ-037 Push with bpu_taken = 1, in_cancel = 00 -> head out_cancel = 2'b10.
REQ-038 Continuous push and pop for 10 entries -> order preserved across two pointer wraps, count stays at 1.
REQ-039 3 entries queued, then flush together with in_valid and out_ready -> next cycle count = 0, out_valid = 0, out_cancel = 11, out_addr = PC_RESET.
REQ-040 2 entries queued, then rstn = 0 for one cycle -> count = 0, in_ready = 1, outputs per REQ-023.

Source files
------------

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_queue
// Purpose  : Circular FIFO between instruction fetch and decode. Each entry
//            holds a fetch address, the fetched word, per-slot compressed
//            flags and per-slot cancel flags. A predicted-taken branch after
//            the primary slot cancels the aux slot as the entry is stored.
//            An empty queue presents an idle entry: PC_RESET, zero data,
//            both slots cancelled.
// Ports    : clk, rstn                  - clock, synchronous active-low reset
//            in_valid/in_ready          - fetch-side handshake
//            in_addr/in_data            - fetch address and instruction word
//            in_cinstr/in_cancel        - [0] primary slot, [1] aux slot
//            bpu_taken                  - redirect after the primary slot
//            flush                      - drop queued and incoming entries
//            out_valid/out_ready        - decode-side handshake
//            out_addr/out_data          - head entry address and word
//            out_cinstr/out_cancel      - head entry slot flags
//            count                      - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       XLEN     = 64,
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] PC_RESET = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [XLEN-1:0]          in_data,
    input  logic [1:0]               in_cinstr,
    input  logic [1:0]               in_cancel,
    input  logic                     bpu_taken,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [XLEN-1:0]          out_data,
    output logic [1:0]               out_cinstr,
    output logic [1:0]               out_cancel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Entry layout: {addr, data, cinstr[1:0], cancel[1:0]}
    localparam int unsigned EW = ADDR_W + XLEN + 4;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    logic            pop;
    logic [1:0]      stored_cancel;
    logic [EW-1:0]   head;

    // Handshake flags depend on registered occupancy only, so a pop in the
    // same cycle never opens room for a push while full.
    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // A taken prediction after the primary slot kills the aux slot.
    assign stored_cancel = bpu_taken ? {1'b1, in_cancel[0]} : in_cancel;

    // Storage: written only on push, never cleared.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_addr, in_data, in_cinstr, stored_cancel};
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head fields; stale storage is masked by the idle entry when empty.
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out_addr   = PC_RESET;
        out_data   = '0;
        out_cinstr = 2'b00;
        out_cancel = 2'b11;
        if (out_valid) begin
            out_addr   = head[EW-1 -: ADDR_W];
            out_data   = head[XLEN+3:4];
            out_cinstr = head[3:2];
            out_cancel = head[1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_queue
// Purpose  : Scoreboard bench for fetch_decode_queue. Accepted pushes are
//            queued as expected entries at issue time; a monitor compares the
//            presented head and occupancy against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_queue;

    localparam int          DEPTH  = 4;
    localparam int          XLEN   = 64;
    localparam int          ADDR_W = 64;
    localparam logic [63:0] PC_RST = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [XLEN-1:0]   in_data;
    logic [1:0]        in_cinstr;
    logic [1:0]        in_cancel;
    logic              bpu_taken;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [XLEN-1:0]   out_data;
    logic [1:0]        out_cinstr;
    logic [1:0]        out_cancel;
    logic [2:0]        count;

    always #5 clk = ~clk;

    fetch_decode_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RST)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_cinstr  (in_cinstr),
        .in_cancel  (in_cancel),
        .bpu_taken  (bpu_taken),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_cinstr (out_cinstr),
        .out_cancel (out_cancel),
        .count      (count)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] word;
        logic [1:0]  ci;
        logic [1:0]  cn;
    } ent_t;

    ent_t exp_q[$];   // expected entries, oldest first
    int   mdl_cnt;    // entries the DUT should hold right now
    bit   pend;       // an accepted push is waiting for the next edge
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the expected entry is queued as soon
    // as the bench knows the push will be accepted at the next rising edge.
    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] ci_i, input logic [1:0] cn_i, input logic bpu,
                         input logic fl, input logic ordy, input logic rn);
        ent_t e;
        @(negedge clk);
        rstn      = rn;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_cinstr = ci_i;
        in_cancel = cn_i;
        bpu_taken = bpu;
        flush     = fl;
        out_ready = ordy;
        if (v && rn && !fl && mdl_cnt < DEPTH) begin
            e.addr = a;
            e.word = d;
            e.ci   = ci_i;
            e.cn   = bpu ? {1'b1, cn_i[0]} : cn_i;
            exp_q.push_back(e);
            pend = 1'b1;
        end
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 64'h0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    task automatic push(input logic [63:0] a, input logic ordy);
        drive(1'b1, a, a ^ 64'h5A5A, 2'b01, 2'b00, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    task automatic do_flush();
        drive(1'b0, 64'h0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: checks the state left by the last edge, then advances the
    // model through the edge the current inputs will produce.
    initial begin : monitor
        ent_t h;
        forever begin
            @(negedge clk);
            #2;
            chk("count", 64'(count), 64'(mdl_cnt));
            chk("in_ready", 64'(in_ready), 64'(mdl_cnt < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(mdl_cnt != 0));
            if (mdl_cnt > 0) begin
                h = exp_q[0];
                chk("head_addr", out_addr, h.addr);
                chk("head_data", out_data, h.word);
                chk("head_cinstr", 64'(out_cinstr), 64'(h.ci));
                chk("head_cancel", 64'(out_cancel), 64'(h.cn));
            end else begin
                chk("idle_addr", out_addr, PC_RST);
                chk("idle_data", out_data, 64'h0);
                chk("idle_cinstr", 64'(out_cinstr), 64'h0);
                chk("idle_cancel", 64'(out_cancel), 64'h3);
            end
            if (!rstn || flush) begin
                exp_q.delete();
                mdl_cnt = 0;
            end else begin
                if (mdl_cnt > 0 && out_ready) begin
                    void'(exp_q.pop_front());
                    mdl_cnt--;
                end
                if (pend) mdl_cnt++;
            end
            pend = 1'b0;
        end
    end

    initial begin : stimulus
        int bias_v;
        int bias_r;
        rstn = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_cinstr = 2'b00; in_cancel = 2'b00; bpu_taken = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        mdl_cnt = 0; pend = 1'b0; n_vec = 0; n_err = 0;

        // Reset state
        drive(1'b0, 64'h0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_cancel", 64'(out_cancel), 64'h3);
        chk("rst_out_addr", out_addr, PC_RST);

        // Single push shows up one cycle later
        drive(1'b1, 64'h1000, 64'h13, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("a_out_valid", 64'(out_valid), 64'h1);
        chk("a_out_addr", out_addr, 64'h1000);
        chk("a_count", 64'(count), 64'h1);

        // Fill to DEPTH; a fifth push is refused, a pop reopens
        do_flush();
        for (int i = 0; i < DEPTH; i++) push(64'h1100 + 64'(4 * i), 1'b0);
        push(64'h1200, 1'b0);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'h0);
        idle(1'b1);
        chk("full_reject", 64'(count), 64'(DEPTH));
        idle(1'b0);
        chk("after_pop_ready", 64'(in_ready), 64'h1);
        chk("after_pop_count", 64'(count), 64'(DEPTH - 1));

        // Predicted-taken cancels the aux slot
        do_flush();
        drive(1'b1, 64'h3000, 64'h77, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("bpu_cancel", 64'(out_cancel), 64'h2);

        // Streaming push+pop across two pointer wraps
        do_flush();
        for (int i = 0; i < 11; i++) begin
            push(64'h2000 + 64'(4 * i), 1'b1);
            if (i > 0) chk("stream_count", 64'(count), 64'h1);
        end
        idle(1'b1);
        chk("stream_last", 64'(count), 64'h1);
        idle(1'b1);
        chk("stream_drained", 64'(count), 64'h0);

        // Flush with concurrent push and pop
        for (int i = 0; i < 3; i++) push(64'h4000 + 64'(4 * i), 1'b0);
        drive(1'b1, 64'h4100, 64'h1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_out_cancel", 64'(out_cancel), 64'h3);
        chk("flush_out_addr", out_addr, PC_RST);

        // Reset mid-operation with concurrent push and pop
        for (int i = 0; i < 2; i++) push(64'h5000 + 64'(4 * i), 1'b0);
        drive(1'b1, 64'h5100, 64'h2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        chk("mrst_count", 64'(count), 64'h0);
        chk("mrst_in_ready", 64'(in_ready), 64'h1);
        chk("mrst_out_valid", 64'(out_valid), 64'h0);
        chk("mrst_out_data", out_data, 64'h0);
        chk("mrst_out_cancel", 64'(out_cancel), 64'h3);

        // Randomized traffic with shifting fill/drain bias
        bias_v = 75;
        bias_r = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                bias_v = $urandom_range(20, 95);
                bias_r = $urandom_range(20, 95);
            end
            drive(($urandom_range(0, 99) < bias_v),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 99) < bias_r),
                  ($urandom_range(0, 127) != 0));
        end

        for (int i = 0; i < 8; i++) idle(1'b1);
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
